// File: rtl/memory.sv
// Register-file store for the Simon pattern sequence: one synchronous write port and one combinational read port.
// Optional macro MEMORY_BYPASS_EN adds write-first forwarding from w_data to r_data on an address match.
module memory #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_en,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic                  w_in_range_s;
  logic                  r_in_range_s;
  logic [DATA_WIDTH-1:0] r_data_s;

  // Addresses at or beyond DEPTH exist only when DEPTH < 2**ADDR_WIDTH.
  assign w_in_range_s = (int'(w_addr) < DEPTH);
  assign r_in_range_s = (int'(r_addr) < DEPTH);

  // Array update: reset wipes every entry and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (w_en && w_in_range_s) begin
      mem_r[w_addr] <= w_data;
    end
  end

  // Combinational read path, zero for out-of-range addresses.
  always_comb begin
    r_data_s = '0;
    if (r_in_range_s) begin
`ifdef MEMORY_BYPASS_EN
      if (w_en && !rst && w_in_range_s && (w_addr == r_addr)) begin
        r_data_s = w_data;
      end else begin
        r_data_s = mem_r[r_addr];
      end
`else
      r_data_s = mem_r[r_addr];
`endif
    end else begin
      r_data_s = '0;
    end
  end

  assign r_data = r_data_s;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed vector table, hand-written corner sequences,
// and a randomized run against an array-based reference model.
module tb_memory;

  logic       clk;
  logic       rst;
  logic [5:0] r_addr;
  logic [5:0] w_addr;
  logic [3:0] w_data;
  logic       w_en;
  logic [3:0] r_data;

  int checks;
  int failures;

`ifdef MEMORY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [3:0] model [64];

  typedef struct {
    logic       rst;
    logic       w_en;
    logic [5:0] w_addr;
    logic [3:0] w_data;
    logic [5:0] r_addr;
    logic [3:0] exp_pre;
    logic [3:0] exp_post;
  } vec_t;

  vec_t vecs [12];

  memory dut (
    .clk    (clk),
    .rst    (rst),
    .r_addr (r_addr),
    .w_addr (w_addr),
    .w_data (w_data),
    .w_en   (w_en),
    .r_data (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Advance one clock edge and apply the same rules to the reference model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 64; i++) model[i] = 4'b0000;
    end else if (w_en) begin
      model[w_addr] = w_data;
    end
    #1;
  endtask

  function automatic logic [3:0] expect_read();
    if (BYPASS && w_en && !rst && (w_addr == r_addr)) return w_data;
    return model[r_addr];
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) model[i] = 4'bxxxx;
    rst = 1'b1; w_en = 1'b0; w_addr = 6'd0; w_data = 4'd0; r_addr = 6'd0;
    #2;
    tick();
    rst = 1'b0;
    #1;
    r_addr = 6'd0;  #1; check("reset_state_a0", r_data, 4'b0000);
    r_addr = 6'd63; #1; check("reset_state_a63", r_data, 4'b0000);

    // Reset clear: write 1010 to 5, then pulse reset and sweep all addresses.
    w_en = 1'b1; w_addr = 6'd5; w_data = 4'b1010; r_addr = 6'd0;
    tick();
    w_en = 1'b0; r_addr = 6'd5; #1;
    check("write_a5", r_data, 4'b1010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 64; a++) begin
      r_addr = 6'(a); #1;
      check("reset_clear_sweep", r_data, 4'b0000);
    end

    // Directed table: pre = before the edge, post = after it with inputs held.
    vecs[0]  = '{1'b0, 1'b1, 6'd1,  4'b0001, 6'd0,  4'b0000, 4'b0000};
    vecs[1]  = '{1'b0, 1'b1, 6'd2,  4'b0010, 6'd1,  4'b0001, 4'b0001};
    vecs[2]  = '{1'b0, 1'b1, 6'd3,  4'b0100, 6'd2,  4'b0010, 4'b0010};
    vecs[3]  = '{1'b0, 1'b1, 6'd4,  4'b1000, 6'd3,  4'b0100, 4'b0100};
    vecs[4]  = '{1'b0, 1'b0, 6'd7,  4'b1111, 6'd4,  4'b1000, 4'b1000};
    vecs[5]  = '{1'b0, 1'b0, 6'd7,  4'b1111, 6'd7,  4'b0000, 4'b0000};
    vecs[6]  = '{1'b0, 1'b0, 6'd7,  4'b1111, 6'd7,  4'b0000, 4'b0000};
    vecs[7]  = '{1'b1, 1'b1, 6'd9,  4'b0100, 6'd1,  4'b0001, 4'b0000};
    vecs[8]  = '{1'b0, 1'b0, 6'd0,  4'b0000, 6'd9,  4'b0000, 4'b0000};
    vecs[9]  = '{1'b0, 1'b1, 6'd63, 4'b0110, 6'd0,  4'b0000, 4'b0000};
    vecs[10] = '{1'b0, 1'b1, 6'd0,  4'b0001, 6'd63, 4'b0110, 4'b0110};
    vecs[11] = '{1'b0, 1'b0, 6'd0,  4'b0000, 6'd0,  4'b0001, 4'b0001};
    for (int v = 0; v < 12; v++) begin
      rst = vecs[v].rst; w_en = vecs[v].w_en; w_addr = vecs[v].w_addr;
      w_data = vecs[v].w_data; r_addr = vecs[v].r_addr;
      #1;
      check($sformatf("vec%0d_pre", v), r_data, vecs[v].exp_pre);
      tick();
      check($sformatf("vec%0d_post", v), r_data, vecs[v].exp_post);
    end
    rst = 1'b0; w_en = 1'b0;
    r_addr = 6'd9;  #1; check("reset_priority_a9", r_data, 4'b0000);
    r_addr = 6'd63; #1; check("boundary_a63", r_data, 4'b0110);
    r_addr = 6'd0;  #1; check("boundary_a0", r_data, 4'b0001);

    // Read-during-write at address 3: old 0010, new 1000.
    w_en = 1'b1; w_addr = 6'd3; w_data = 4'b0010; r_addr = 6'd0;
    tick();
    w_data = 4'b1000; r_addr = 6'd3; #1;
    check("rdw_before_edge", r_data, BYPASS ? 4'b1000 : 4'b0010);
    tick();
    w_en = 1'b0; #1;
    check("rdw_after_edge", r_data, 4'b1000);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      w_en   = $urandom_range(0, 1);
      w_addr = 6'($urandom_range(0, 63));
      w_data = 4'($urandom_range(0, 15));
      r_addr = ($urandom_range(0, 3) == 0) ? w_addr : 6'($urandom_range(0, 63));
      #1;
      check("random_read", r_data, expect_read());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
